// File: rtl/detect_compare_monitor_if.sv
// Signal bundle between the detector pair and the compare monitor.
// Protocol: no valid/ready; every input is sampled on each rising clk edge and every output is a register.
interface detect_compare_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             w_moore;
    logic             w_mealy;
    logic [CNT_W-1:0] moore_cnt;
    logic [CNT_W-1:0] mealy_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] first_err;
    logic             mismatch;
    logic             err_sticky;
    logic             fault;
    logic             busy;

    modport master (
        output en, clr, w_moore, w_mealy,
        input  moore_cnt, mealy_cnt, err_cnt, cyc_cnt, first_err,
        input  mismatch, err_sticky, fault, busy
    );

    modport slave (
        input  en, clr, w_moore, w_mealy,
        output moore_cnt, mealy_cnt, err_cnt, cyc_cnt, first_err,
        output mismatch, err_sticky, fault, busy
    );
endinterface

// File: rtl/detect_compare_monitor.sv
// Aligns the Mealy detect output to the Moore output, compares them every RUN
// cycle, counts detections/mismatches and latches FAULT at the error limit.
module detect_compare_monitor #(
    parameter int CNT_W       = 8,
    parameter int ALIGN_DELAY = 1,
    parameter int ERR_LIMIT   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    detect_compare_monitor_if.slave mon,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ERR_LIM = CNT_W'(ERR_LIMIT);

    state_t                 state_q, state_d;
    logic [1:0]             warm_q, warm_d;
    logic [ALIGN_DELAY-1:0] dly_q, dly_d;
    logic [CNT_W-1:0]       moore_cnt_q, moore_cnt_d;
    logic [CNT_W-1:0]       mealy_cnt_q, mealy_cnt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]       cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]       first_err_q, first_err_d;
    logic                   mismatch_q, mismatch_d;
    logic                   sticky_q, sticky_d;
    logic                   mealy_al;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign mealy_al = dly_q[ALIGN_DELAY-1];

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        moore_cnt_d = moore_cnt_q;
        mealy_cnt_d = mealy_cnt_q;
        err_cnt_d   = err_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        first_err_d = first_err_q;
        mismatch_d  = 1'b0;
        sticky_d    = sticky_q;
        dly_d       = dly_q;
        dly_d[0]    = mon.w_mealy;
        for (int i = 1; i < ALIGN_DELAY; i++) dly_d[i] = dly_q[i-1];

        case (state_q)
            IDLE: begin
                if (mon.en) begin
                    state_d = WARMUP;
                    warm_d  = 2'(ALIGN_DELAY - 1);
                end
            end
            WARMUP: begin
                if (!mon.en)            state_d = IDLE;
                else if (warm_q == 2'd0) state_d = RUN;
                else                    warm_d  = warm_q - 1'b1;
            end
            RUN: begin
                if (!mon.en) begin
                    state_d = IDLE;
                end else begin
                    cyc_cnt_d = sat_inc(cyc_cnt_q);
                    if (mon.w_moore) moore_cnt_d = sat_inc(moore_cnt_q);
                    if (mealy_al)    mealy_cnt_d = sat_inc(mealy_cnt_q);
                    if (mealy_al != mon.w_moore) begin
                        mismatch_d = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        sticky_d   = 1'b1;
                        // first_err captures the pre-increment cycle count
                        if (!sticky_q) first_err_d = cyc_cnt_q;
                        if (err_cnt_d == ERR_LIM || err_cnt_d == CNT_MAX) state_d = FAULT;
                    end
                end
            end
            FAULT: ;
            default: state_d = IDLE;
        endcase

        if (mon.clr) begin
            state_d     = IDLE;
            warm_d      = 2'd0;
            dly_d       = '0;
            moore_cnt_d = '0;
            mealy_cnt_d = '0;
            err_cnt_d   = '0;
            cyc_cnt_d   = '0;
            first_err_d = '0;
            mismatch_d  = 1'b0;
            sticky_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            warm_q      <= 2'd0;
            dly_q       <= '0;
            moore_cnt_q <= '0;
            mealy_cnt_q <= '0;
            err_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            first_err_q <= '0;
            mismatch_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            dly_q       <= dly_d;
            moore_cnt_q <= moore_cnt_d;
            mealy_cnt_q <= mealy_cnt_d;
            err_cnt_q   <= err_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            first_err_q <= first_err_d;
            mismatch_q  <= mismatch_d;
            sticky_q    <= sticky_d;
        end
    end

    assign mon.moore_cnt  = moore_cnt_q;
    assign mon.mealy_cnt  = mealy_cnt_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.cyc_cnt    = cyc_cnt_q;
    assign mon.first_err  = first_err_q;
    assign mon.mismatch   = mismatch_q;
    assign mon.err_sticky = sticky_q;
    assign mon.fault      = (state_q == FAULT);
    assign mon.busy       = (state_q == WARMUP) || (state_q == RUN);
    assign dbg_state_o    = state_q;
endmodule
